// File: rtl/mem_arbiter.sv
// mem_arbiter: arbitrates the fetch and load/store requesters onto one
// single-ported word memory. Data accesses win contention, but after
// MAX_DATA_STREAK back-to-back contended data grants the fetch path is
// forced through. Each granted request spends one ACCESS cycle on the
// memory. The owner of the request gets a one-cycle response strobe in
// the cycle after that.
module mem_arbiter #(
    parameter int unsigned WIDTH           = 32,
    parameter int unsigned MAX_DATA_STREAK = 4
) (
    input  logic             clk,
    input  logic             rst,

    input  logic             if_req_valid,
    output logic             if_req_ready,
    input  logic [WIDTH-1:0] if_addr,
    output logic             if_rsp_valid,
    output logic [WIDTH-1:0] if_rsp_data,

    input  logic             d_req_valid,
    output logic             d_req_ready,
    input  logic [WIDTH-1:0] d_addr,
    input  logic [WIDTH-1:0] d_wdata,
    input  logic             d_we,
    output logic             d_rsp_valid,
    output logic [WIDTH-1:0] d_rsp_rdata,

    output logic [WIDTH-1:0] m_addr,
    output logic [WIDTH-1:0] m_wdata,
    output logic             m_we,
    input  logic [WIDTH-1:0] m_rdata
);

    localparam int unsigned   SW         = $clog2(MAX_DATA_STREAK + 1);
    localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_DATA_STREAK);

    if (MAX_DATA_STREAK < 1) begin : g_bad_streak
        $error("mem_arbiter: MAX_DATA_STREAK must be at least 1");
    end

    typedef enum logic {
        IDLE,
        ACCESS
    } state_t;

    typedef enum logic {
        OWN_FETCH,
        OWN_DATA
    } owner_t;

    state_t           state, state_next;
    logic [SW-1:0]    streak, streak_next;
    logic             grant_d, grant_i;

    logic [WIDTH-1:0] cmd_addr;
    logic [WIDTH-1:0] cmd_wdata;
    logic             cmd_we;
    owner_t           cmd_owner;

    // Grant decision, next state and streak update.
    always_comb begin
        d_req_ready  = 1'b0;
        if_req_ready = 1'b0;
        state_next   = state;
        streak_next  = streak;

        if (state == IDLE && !rst) begin
            // The two conditions are exclusive when both valids are high:
            // streak < MAX picks data and streak == MAX picks fetch.
            d_req_ready  = d_req_valid  && (!if_req_valid || streak <  STREAK_MAX);
            if_req_ready = if_req_valid && (!d_req_valid  || streak == STREAK_MAX);
        end

        grant_d = d_req_ready;
        grant_i = if_req_ready;

        case (state)
            IDLE:    if (grant_d || grant_i) state_next = ACCESS;
            ACCESS:  state_next = IDLE;
            default: state_next = IDLE;
        endcase

        if (grant_i) begin
            streak_next = '0;
        end else if (grant_d && if_req_valid && streak < STREAK_MAX) begin
            streak_next = streak + 1'b1;
        end
    end

    // State register and streak counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            streak <= '0;
        end else begin
            state  <= state_next;
            streak <= streak_next;
        end
    end

    // Command register: captures the granted request for its ACCESS cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            cmd_addr  <= '0;
            cmd_wdata <= '0;
            cmd_we    <= 1'b0;
            cmd_owner <= OWN_FETCH;
        end else if (grant_d) begin
            cmd_addr  <= {d_addr[WIDTH-1:2], 2'b00};
            cmd_wdata <= d_wdata;
            cmd_we    <= d_we;
            cmd_owner <= OWN_DATA;
        end else if (grant_i) begin
            cmd_addr  <= {if_addr[WIDTH-1:2], 2'b00};
            cmd_wdata <= '0;
            cmd_we    <= 1'b0;
            cmd_owner <= OWN_FETCH;
        end
    end

    // Response registers: the owner captures read data (or 0 for a store)
    // at the end of ACCESS; the other requester's data is left untouched.
    always_ff @(posedge clk) begin
        if (rst) begin
            if_rsp_valid <= 1'b0;
            d_rsp_valid  <= 1'b0;
            if_rsp_data  <= '0;
            d_rsp_rdata  <= '0;
        end else begin
            if_rsp_valid <= 1'b0;
            d_rsp_valid  <= 1'b0;
            if (state == ACCESS) begin
                if (cmd_owner == OWN_FETCH) begin
                    if_rsp_valid <= 1'b1;
                    if_rsp_data  <= m_rdata;
                end else begin
                    d_rsp_valid  <= 1'b1;
                    d_rsp_rdata  <= cmd_we ? '0 : m_rdata;
                end
            end
        end
    end

    // Memory port: address/data hold the last command between accesses.
    // The write enable is gated by rst so that an aborted store never commits.
    always_comb begin
        m_addr  = cmd_addr;
        m_wdata = cmd_wdata;
        m_we    = (state == ACCESS) && cmd_we && !rst;
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter with a behavioural word
// memory (asynchronous read, write on the rising edge).
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        if_req_valid = 1'b0;
    logic        if_req_ready;
    logic [31:0] if_addr = '0;
    logic        if_rsp_valid;
    logic [31:0] if_rsp_data;
    logic        d_req_valid = 1'b0;
    logic        d_req_ready;
    logic [31:0] d_addr = '0;
    logic [31:0] d_wdata = '0;
    logic        d_we = 1'b0;
    logic        d_rsp_valid;
    logic [31:0] d_rsp_rdata;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic        m_we;
    logic [31:0] m_rdata;

    logic [31:0] mem [0:63];

    int checks = 0;
    int passed = 0;
    int failed = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.WIDTH(32), .MAX_DATA_STREAK(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .if_req_valid (if_req_valid),
        .if_req_ready (if_req_ready),
        .if_addr      (if_addr),
        .if_rsp_valid (if_rsp_valid),
        .if_rsp_data  (if_rsp_data),
        .d_req_valid  (d_req_valid),
        .d_req_ready  (d_req_ready),
        .d_addr       (d_addr),
        .d_wdata      (d_wdata),
        .d_we         (d_we),
        .d_rsp_valid  (d_rsp_valid),
        .d_rsp_rdata  (d_rsp_rdata),
        .m_addr       (m_addr),
        .m_wdata      (m_wdata),
        .m_we         (m_we),
        .m_rdata      (m_rdata)
    );

    // Behavioural memory.
    assign m_rdata = mem[m_addr[7:2]];
    always @(posedge clk) if (m_we) mem[m_addr[7:2]] <= m_wdata;

    initial for (int i = 0; i < 64; i++) mem[i] = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic settle();
        #1;
    endtask

    // Uncontended data access: handshake, ACCESS, response.
    task automatic access_d(input logic [31:0] a, input logic [31:0] wd,
                            input logic we, input logic [31:0] exp_rd);
        cyc();
        d_req_valid = 1'b1; d_addr = a; d_wdata = wd; d_we = we;
        settle();
        chk("d_ready", {31'd0, d_req_ready}, 32'd1);
        cyc();
        d_req_valid = 1'b0;
        settle();
        chk("d_m_addr", m_addr, {a[31:2], 2'b00});
        chk("d_m_we", {31'd0, m_we}, {31'd0, we});
        cyc();
        settle();
        chk("d_rsp_valid", {31'd0, d_rsp_valid}, 32'd1);
        chk("d_rsp_rdata", d_rsp_rdata, exp_rd);
        chk("d_if_rsp_quiet", {31'd0, if_rsp_valid}, 32'd0);
    endtask

    // Uncontended fetch: handshake, ACCESS, response.
    task automatic access_i(input logic [31:0] a, input logic [31:0] exp_rd);
        cyc();
        if_req_valid = 1'b1; if_addr = a;
        settle();
        chk("i_ready", {31'd0, if_req_ready}, 32'd1);
        cyc();
        if_req_valid = 1'b0;
        settle();
        chk("i_m_addr", m_addr, {a[31:2], 2'b00});
        chk("i_m_we", {31'd0, m_we}, 32'd0);
        cyc();
        settle();
        chk("i_rsp_valid", {31'd0, if_rsp_valid}, 32'd1);
        chk("i_rsp_data", if_rsp_data, exp_rd);
    endtask

    initial begin
        logic exp_d, exp_i;

        // Reset held two cycles with both requests present.
        rst = 1'b1; if_req_valid = 1'b1; d_req_valid = 1'b1; d_we = 1'b1;
        cyc(); settle();
        chk("rst_d_ready", {31'd0, d_req_ready}, 32'd0);
        chk("rst_i_ready", {31'd0, if_req_ready}, 32'd0);
        cyc(); settle();
        chk("rst_d_ready2", {31'd0, d_req_ready}, 32'd0);
        chk("rst_i_ready2", {31'd0, if_req_ready}, 32'd0);
        chk("rst_if_rsp_valid", {31'd0, if_rsp_valid}, 32'd0);
        chk("rst_d_rsp_valid", {31'd0, d_rsp_valid}, 32'd0);
        chk("rst_if_rsp_data", if_rsp_data, 32'd0);
        chk("rst_d_rsp_rdata", d_rsp_rdata, 32'd0);
        chk("rst_m_addr", m_addr, 32'd0);
        chk("rst_m_wdata", m_wdata, 32'd0);
        chk("rst_m_we", {31'd0, m_we}, 32'd0);

        // First IDLE cycle after release: data wins against fetch.
        cyc();
        rst = 1'b0; d_addr = 32'h4; d_wdata = 32'hCAFEBABE; d_we = 1'b1; if_addr = 32'h0;
        settle();
        chk("rel_d_ready", {31'd0, d_req_ready}, 32'd1);
        chk("rel_i_ready", {31'd0, if_req_ready}, 32'd0);
        cyc();
        d_req_valid = 1'b0; if_req_valid = 1'b0;
        settle();
        chk("st_m_we", {31'd0, m_we}, 32'd1);
        chk("st_m_addr", m_addr, 32'h4);
        chk("st_m_wdata", m_wdata, 32'hCAFEBABE);
        chk("st_access_ready", {31'd0, d_req_ready}, 32'd0);
        cyc(); settle();
        chk("st_rsp_valid", {31'd0, d_rsp_valid}, 32'd1);
        chk("st_rsp_rdata", d_rsp_rdata, 32'd0);
        chk("st_m_we_off", {31'd0, m_we}, 32'd0);
        cyc(); settle();
        chk("st_rsp_pulse", {31'd0, d_rsp_valid}, 32'd0);

        // Fetch of the stored word.
        access_i(32'h4, 32'hCAFEBABE);

        // Alignment: store at 0x8, load at 0x9.
        access_d(32'h8, 32'h12345678, 1'b1, 32'h0);
        access_d(32'h9, 32'h0, 1'b0, 32'h12345678);
        chk("if_data_untouched", if_rsp_data, 32'hCAFEBABE);

        // Contention: D,D,D,D,I repeated, one grant every two cycles.
        for (int k = 0; k < 20; k++) begin
            cyc();
            if (k == 0) begin
                d_req_valid = 1'b1; d_we = 1'b0; d_addr = 32'h8;
                if_req_valid = 1'b1; if_addr = 32'h4;
            end
            settle();
            if (k % 2 == 0) begin
                exp_d = ((k / 2) % 5) != 4;
                exp_i = !exp_d;
            end else begin
                exp_d = 1'b0;
                exp_i = 1'b0;
            end
            chk($sformatf("cont_d_%0d", k), {31'd0, d_req_ready}, {31'd0, exp_d});
            chk($sformatf("cont_i_%0d", k), {31'd0, if_req_ready}, {31'd0, exp_i});
            chk($sformatf("cont_streak_%0d", k), 32'(dut.streak) > 32'd4 ? 32'd1 : 32'd0, 32'd0);
        end
        cyc();
        d_req_valid = 1'b0; if_req_valid = 1'b0;
        settle();
        chk("cont_last_if_rsp", {31'd0, if_rsp_valid}, 32'd1);
        chk("cont_streak_clear", 32'(dut.streak), 32'd0);

        // Uncontended data stream: streak stays 0.
        for (int k = 0; k < 20; k++) begin
            cyc();
            if (k == 0) begin
                d_req_valid = 1'b1; d_we = 1'b0; d_addr = 32'h8; if_req_valid = 1'b0;
            end
            if (k == 19) begin
                d_req_valid = 1'b0; if_req_valid = 1'b1; if_addr = 32'h4;
            end
            settle();
            if (k < 19) begin
                chk($sformatf("unc_d_%0d", k), {31'd0, d_req_ready}, (k % 2 == 0) ? 32'd1 : 32'd0);
            end else begin
                chk("unc_i_wait", {31'd0, if_req_ready}, 32'd0);
                chk("unc_streak", 32'(dut.streak), 32'd0);
            end
        end
        cyc(); settle();
        chk("unc_i_ready", {31'd0, if_req_ready}, 32'd1);
        chk("unc_d_rsp", {31'd0, d_rsp_valid}, 32'd1);
        cyc();
        if_req_valid = 1'b0;
        settle();
        cyc(); settle();
        chk("unc_i_rsp", {31'd0, if_rsp_valid}, 32'd1);
        chk("unc_i_data", if_rsp_data, 32'hCAFEBABE);

        // Reset during ACCESS of a store.
        access_d(32'h10, 32'h11111111, 1'b1, 32'h0);
        cyc();
        d_req_valid = 1'b1; d_addr = 32'h10; d_wdata = 32'hDEADBEEF; d_we = 1'b1;
        settle();
        chk("abort_d_ready", {31'd0, d_req_ready}, 32'd1);
        cyc();
        d_req_valid = 1'b0; rst = 1'b1;
        settle();
        chk("abort_m_we", {31'd0, m_we}, 32'd0);
        cyc();
        rst = 1'b0;
        settle();
        chk("abort_rsp", {31'd0, d_rsp_valid}, 32'd0);
        chk("abort_m_addr", m_addr, 32'd0);
        chk("abort_if_data", if_rsp_data, 32'd0);
        cyc(); settle();
        chk("abort_rsp2", {31'd0, d_rsp_valid}, 32'd0);
        chk("abort_mem", mem[4], 32'h11111111);
        access_d(32'h10, 32'h0, 1'b0, 32'h11111111);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    // Global time bound so the run always ends.
    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester arbiter that shares one single-ported word memory (asynchronous read, write committed on `clk` rising edge) between the instruction-fetch path and the load/store path of the LX32 core. Each requester uses a valid/ready request handshake and gets a one-cycle response pulse. Data accesses have priority, and a bounded-streak counter guarantees fetch forward progress. The block sits between the core's fetch/LSU ports and `memory_sim` (or a later real RAM), driving that memory's data-side port.

## Interface
- `WIDTH`, 32: address/data width.
- `MAX_DATA_STREAK`, 4: maximum consecutive contended data grants before fetch is forced; must be ≥ 1.

- `clk`  in  1  single clock; all state on rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `if_req_valid`  in  1  fetch request present.
- `if_req_ready`  out  1  fetch request accepted this cycle.
- `if_addr`  in  WIDTH  fetch byte address.
- `if_rsp_valid`  out  1  one-cycle fetch response strobe.
- `if_rsp_data`  out  WIDTH  fetched word; held until next fetch response.
- `d_req_valid`  in  1  load/store request present.
- `d_req_ready`  out  1  load/store accepted this cycle.
- `d_addr`  in  WIDTH  load/store byte address.
- `d_wdata`  in  WIDTH  store data.
- `d_we`  in  1  1 = store, 0 = load.
- `d_rsp_valid`  out  1  one-cycle load/store completion strobe; stores also pulse it.
- `d_rsp_rdata`  out  WIDTH  load data; 0 after a store; held until next data response.
- `m_addr`  out  WIDTH  memory address, word-aligned: bits [1:0] forced to 0.
- `m_wdata`  out  WIDTH  memory write data.
- `m_we`  out  1  memory write enable.
- `m_rdata`  in  WIDTH  memory asynchronous read data.

## Operation
- FSM states: IDLE, ACCESS.
  - IDLE → ACCESS on any handshake (valid && ready).
  - ACCESS → IDLE unconditionally after one cycle.
- Readiness and grant:
  - Both `*_req_ready` are 0 outside IDLE.
  - In IDLE, ready is combinational from the valids and the streak counter.
  - `d_req_ready = d_req_valid && (!if_req_valid || streak < MAX_DATA_STREAK)`.
  - `if_req_ready = if_req_valid && (!d_req_valid || streak == MAX_DATA_STREAK)`.
  - At most one grant per cycle.
- Streak counter (width `$clog2(MAX_DATA_STREAK+1)`):
  - +1 on a data grant while `if_req_valid` = 1.
  - Cleared on any fetch grant.
  - Unchanged otherwise.
  - Never exceeds `MAX_DATA_STREAK`.
- On a grant, the command register latches addr (aligned), wdata, we, and owner (fetch/data). Fetch always latches we = 0.
- ACCESS cycle drives the memory from the command register:
  - `m_addr`, `m_wdata`.
  - `m_we = cmd_we && !rst`.
  - The memory commits the store at the end of the ACCESS cycle.
- End of ACCESS, owner's response register loads:
  - Read: `m_rdata`.
  - Store: 0.
  - The owner's `*_rsp_valid` is set for the next cycle only.
- The other requester's response data register is untouched.
- No response backpressure: requesters must accept the strobe cycle.
- In IDLE: `m_we` = 0; `m_addr`/`m_wdata` hold last command values.
- Reset (any state): state → IDLE; streak, command register, both `*_rsp_valid`, both rsp data registers, `m_addr`, `m_wdata` → 0.
  - Reset asserted during ACCESS: `m_we` gated low, so no write commits.
  - The aborted access produces no response.
- Requests present while `rst` = 1 are not accepted (ready forced 0).

## Timing
- Request handshake at rising edge N.
- ACCESS during cycle N+1; store committed at edge ending N+1.
- `*_rsp_valid` high during cycle N+2; the new request can handshake in the same cycle N+2.
- Load-use latency 2 cycles; sustained throughput 1 access per 2 cycles.
- `*_req_ready` has a combinational path from both `*_req_valid` inputs and registered state only; no path from `m_rdata`.
- Reset value of every output:
  - 0 for all outputs, except ready, which is 0 by construction while `rst` = 1.

## Test plan
- Reset: hold `rst` 2 cycles with both valids high → all outputs 0, no grants; after release, first data grant in the first IDLE cycle.
- Store then fetch: store 0xCAFEBABE @0x4 → `m_we` high exactly one cycle, `d_rsp_valid` 2 cycles after handshake with `d_rsp_rdata` = 0; fetch @0x4 → `if_rsp_data` = 0xCAFEBABE 2 cycles after handshake.
- Alignment: store 0x12345678 @0x8, load @0x9 → `m_addr` = 0x8 during ACCESS, `d_rsp_rdata` = 0x12345678.
- Contention (MAX = 4): both valids held high → grant order D,D,D,D,I,D,D,D,D,I; one grant every 2 cycles; streak never exceeds 4.
- Uncontended data: `d_req_valid` held, `if_req_valid` = 0 for 10 grants → streak stays 0; a fetch raised afterwards waits only for the current access.
- Reset mid-access: assert `rst` during ACCESS of store 0xDEADBEEF @0x10 → `m_we` = 0 that cycle, word @0x10 keeps its old value, no `d_rsp_valid`.
